// File: rtl/prc_reconfig_timer.sv
// Per-socket partial-reconfiguration decouple window timer.
// One channel instance per virtual socket; lane 0 = shift, lane 1 = count.

module prc_reconfig_timer_ch #(
  parameter int CNT_WIDTH   = 32,
  parameter int CAP_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 dec,
  input  logic                 cap,
  input  logic                 ack,
  input  logic                 clear_stats,
  output logic [CNT_WIDTH-1:0] lat_time,
  output logic                 valid,
  output logic [CNT_WIDTH-1:0] max_time,
  output logic                 ovf,
  output logic                 miss,
  output logic                 spur
);
  typedef enum logic [1:0] {IDLE, RUN, ARMED} state_t;

  localparam logic [7:0]           TMO_LAST = 8'(CAP_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic [7:0]           tmo, tmo_d;
  logic                 latch, set_ovf, set_miss, set_spur;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    tmo_d    = tmo;
    latch    = 1'b0;
    set_ovf  = 1'b0;
    set_miss = 1'b0;
    set_spur = 1'b0;
    case (state)
      IDLE: begin
        if (cap) set_spur = 1'b1;
        if (dec) begin
          state_d = RUN;
          cnt_d   = ONE;
        end
      end
      RUN: begin
        if (cap) begin
          latch   = 1'b1;
          state_d = IDLE;
        end else if (dec) begin
          // Saturate: ovf flags an increment attempted past all-ones.
          if (&cnt) set_ovf = 1'b1;
          else      cnt_d   = cnt + ONE;
        end else begin
          state_d = ARMED;
          tmo_d   = 8'd0;
        end
      end
      ARMED: begin
        if (cap) begin
          latch   = 1'b1;
          state_d = IDLE;
        end else if (dec) begin
          set_miss = 1'b1;
          state_d  = RUN;
          cnt_d    = ONE;
        end else if (tmo == TMO_LAST) begin
          set_miss = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      tmo      <= '0;
      lat_time <= '0;
      valid    <= 1'b0;
      max_time <= '0;
      ovf      <= 1'b0;
      miss     <= 1'b0;
      spur     <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      tmo   <= tmo_d;
      if (latch)    lat_time <= cnt;
      if (latch)    valid    <= 1'b1;
      else if (ack) valid    <= 1'b0;
      // A latch coinciding with clear_stats seeds the fresh maximum.
      if (clear_stats)                  max_time <= latch ? cnt : '0;
      else if (latch && cnt > max_time) max_time <= cnt;
      ovf  <= set_ovf  | (ovf  & ~clear_stats);
      miss <= set_miss | (miss & ~clear_stats);
      spur <= set_spur | (spur & ~clear_stats);
    end
  end
endmodule

module prc_reconfig_timer #(
  parameter int CNT_WIDTH   = 32,
  parameter int CAP_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 vs_shift_decouple,
  input  logic                 vs_count_decouple,
  input  logic                 vs_shift_capture,
  input  logic                 vs_count_capture,
  input  logic                 shift_ack,
  input  logic                 count_ack,
  input  logic                 clear_stats,
  output logic [CNT_WIDTH-1:0] shift_time,
  output logic [CNT_WIDTH-1:0] count_time,
  output logic                 shift_valid,
  output logic                 count_valid,
  output logic [CNT_WIDTH-1:0] shift_max,
  output logic [CNT_WIDTH-1:0] count_max,
  output logic                 shift_ovf,
  output logic                 count_ovf,
  output logic                 shift_miss,
  output logic                 count_miss,
  output logic                 shift_spur,
  output logic                 count_spur
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]                dec, cap, ack;
  logic [NUM_LANES-1:0][CNT_WIDTH-1:0] lat_time, max_time;
  logic [NUM_LANES-1:0]                valid, ovf, miss, spur;

  assign dec = {vs_count_decouple, vs_shift_decouple};
  assign cap = {vs_count_capture,  vs_shift_capture};
  assign ack = {count_ack,         shift_ack};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
    prc_reconfig_timer_ch #(
      .CNT_WIDTH  (CNT_WIDTH),
      .CAP_TIMEOUT(CAP_TIMEOUT)
    ) u_ch (
      .clk        (clk),
      .resetn     (resetn),
      .dec        (dec[g]),
      .cap        (cap[g]),
      .ack        (ack[g]),
      .clear_stats(clear_stats),
      .lat_time   (lat_time[g]),
      .valid      (valid[g]),
      .max_time   (max_time[g]),
      .ovf        (ovf[g]),
      .miss       (miss[g]),
      .spur       (spur[g])
    );
  end

  assign shift_time  = lat_time[0];
  assign count_time  = lat_time[1];
  assign shift_max   = max_time[0];
  assign count_max   = max_time[1];
  assign shift_valid = valid[0];
  assign count_valid = valid[1];
  assign shift_ovf   = ovf[0];
  assign count_ovf   = ovf[1];
  assign shift_miss  = miss[0];
  assign count_miss  = miss[1];
  assign shift_spur  = spur[0];
  assign count_spur  = spur[1];
endmodule

// File: tb/tb_prc_reconfig_timer.sv
// Directed bench: a 32-bit instance plus a 4-bit instance sharing the same stimulus.

module tb_prc_reconfig_timer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sdec = 1'b0, cdec = 1'b0, scap = 1'b0, ccap = 1'b0;
  logic sack = 1'b0, cack = 1'b0, clr = 1'b0;

  logic [31:0] s_time, c_time, s_max, c_max;
  logic        s_valid, c_valid, s_ovf, c_ovf, s_miss, c_miss, s_spur, c_spur;
  logic [3:0]  n_s_time, n_c_time, n_s_max, n_c_max;
  logic        n_s_valid, n_c_valid, n_s_ovf, n_c_ovf, n_s_miss, n_c_miss, n_s_spur, n_c_spur;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prc_reconfig_timer #(.CNT_WIDTH(32), .CAP_TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .vs_shift_decouple(sdec), .vs_count_decouple(cdec),
    .vs_shift_capture(scap), .vs_count_capture(ccap),
    .shift_ack(sack), .count_ack(cack), .clear_stats(clr),
    .shift_time(s_time), .count_time(c_time),
    .shift_valid(s_valid), .count_valid(c_valid),
    .shift_max(s_max), .count_max(c_max),
    .shift_ovf(s_ovf), .count_ovf(c_ovf),
    .shift_miss(s_miss), .count_miss(c_miss),
    .shift_spur(s_spur), .count_spur(c_spur)
  );

  prc_reconfig_timer #(.CNT_WIDTH(4), .CAP_TIMEOUT(16)) dut_n (
    .clk(clk), .resetn(resetn),
    .vs_shift_decouple(sdec), .vs_count_decouple(cdec),
    .vs_shift_capture(scap), .vs_count_capture(ccap),
    .shift_ack(sack), .count_ack(cack), .clear_stats(clr),
    .shift_time(n_s_time), .count_time(n_c_time),
    .shift_valid(n_s_valid), .count_valid(n_c_valid),
    .shift_max(n_s_max), .count_max(n_c_max),
    .shift_ovf(n_s_ovf), .count_ovf(n_c_ovf),
    .shift_miss(n_s_miss), .count_miss(n_c_miss),
    .shift_spur(n_s_spur), .count_spur(n_c_spur)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shift window of n sampled-high edges, capture one cycle after dec falls.
  task automatic shift_win(input int n);
    sdec = 1'b1; tick(n);
    sdec = 1'b0; tick(1);
    scap = 1'b1; tick(1);
    scap = 1'b0;
  endtask

  task automatic shift_ack_pulse();
    sack = 1'b1; tick(1);
    sack = 1'b0;
  endtask

  task automatic clear_pulse();
    clr = 1'b1; tick(1);
    clr = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_s_time", s_time, 0);
    chk("rst_s_valid", {31'd0, s_valid}, 0);
    chk("rst_c_max", c_max, 0);
    chk("rst_flags", {26'd0, s_ovf, c_ovf, s_miss, c_miss, s_spur, c_spur}, 0);
    resetn = 1'b1;
    tick(1);

    // 20-cycle window: 32-bit counts exactly, 4-bit saturates at 15
    shift_win(20);
    chk("w20_time", s_time, 20);
    chk("w20_ovf", {31'd0, s_ovf}, 0);
    chk("n_time_sat", {28'd0, n_s_time}, 15);
    chk("n_ovf", {31'd0, n_s_ovf}, 1);
    chk("n_max", {28'd0, n_s_max}, 15);

    clear_pulse();
    chk("n_clr_ovf", {31'd0, n_s_ovf}, 0);
    chk("n_clr_max", {28'd0, n_s_max}, 0);
    chk("n_clr_time", {28'd0, n_s_time}, 15);
    chk("clr_s_max", s_max, 0);
    chk("clr_s_valid", {31'd0, s_valid}, 1);
    shift_ack_pulse();
    chk("ack_valid", {31'd0, s_valid}, 0);

    // 100-cycle shift window, count channel untouched
    shift_win(100);
    chk("w100_time", s_time, 100);
    chk("w100_valid", {31'd0, s_valid}, 1);
    chk("w100_max", s_max, 100);
    chk("w100_c_time", c_time, 0);
    chk("w100_c_valid", {31'd0, c_valid}, 0);
    shift_ack_pulse();

    // 50 / 200 / 30 sequence with acks
    clear_pulse();
    shift_win(50);
    chk("w50_time", s_time, 50);
    chk("w50_max", s_max, 50);
    shift_ack_pulse();
    chk("w50_ack", {31'd0, s_valid}, 0);
    shift_win(200);
    chk("w200_time", s_time, 200);
    chk("w200_max", s_max, 200);
    shift_ack_pulse();
    chk("w200_ack", {31'd0, s_valid}, 0);
    shift_win(30);
    chk("w30_time", s_time, 30);
    chk("w30_max", s_max, 200);
    shift_ack_pulse();
    chk("w30_ack", {31'd0, s_valid}, 0);

    // Count channel capture timeout: 16 edges in ARMED
    cdec = 1'b1; tick(5);
    cdec = 1'b0; tick(1);
    tick(15);
    chk("tmo_early", {31'd0, c_miss}, 0);
    tick(1);
    chk("tmo_miss", {31'd0, c_miss}, 1);
    chk("tmo_valid", {31'd0, c_valid}, 0);
    ccap = 1'b1; tick(1);
    ccap = 1'b0;
    chk("idle_spur", {31'd0, c_spur}, 1);
    chk("idle_valid", {31'd0, c_valid}, 0);
    chk("s_miss_clean", {31'd0, s_miss}, 0);
    chk("s_spur_clean", {31'd0, s_spur}, 0);

    // Parallel 64-cycle windows; shift ack coincides with capture
    sdec = 1'b1; cdec = 1'b1; tick(64);
    sdec = 1'b0; cdec = 1'b0; tick(1);
    scap = 1'b1; ccap = 1'b1; sack = 1'b1; tick(1);
    scap = 1'b0; ccap = 1'b0; sack = 1'b0;
    chk("par_s_time", s_time, 64);
    chk("par_c_time", c_time, 64);
    chk("par_s_valid", {31'd0, s_valid}, 1);
    chk("par_c_valid", {31'd0, c_valid}, 1);
    chk("par_c_max", c_max, 64);

    // Asynchronous reset mid-RUN at cnt=37, release with dec still high
    sdec = 1'b1; tick(37);
    resetn = 1'b0; #1;
    chk("arst_s_time", s_time, 0);
    chk("arst_s_max", s_max, 0);
    chk("arst_valid", {30'd0, s_valid, c_valid}, 0);
    chk("arst_c_time", c_time, 0);
    chk("arst_flags", {26'd0, s_ovf, c_ovf, s_miss, c_miss, s_spur, c_spur}, 0);
    tick(1);
    resetn = 1'b1;
    tick(10);
    sdec = 1'b0; tick(1);
    scap = 1'b1; tick(1);
    scap = 1'b0;
    chk("rel_time", s_time, 10);
    chk("rel_max", s_max, 10);
    chk("rel_miss", {31'd0, s_miss}, 0);
    shift_ack_pulse();

    // dec returns while ARMED: miss and restart from 1
    sdec = 1'b1; tick(5);
    sdec = 1'b0; tick(1);
    sdec = 1'b1; tick(1);
    chk("restart_miss", {31'd0, s_miss}, 1);
    tick(2);
    sdec = 1'b0; tick(1);
    scap = 1'b1; tick(1);
    scap = 1'b0;
    chk("restart_time", s_time, 3);

    // clear_stats with a spurious capture in the same cycle: set wins
    ccap = 1'b1; clr = 1'b1; tick(1);
    ccap = 1'b0; clr = 1'b0;
    chk("clr_spur_wins", {31'd0, c_spur}, 1);
    chk("clr_s_miss", {31'd0, s_miss}, 0);
    chk("clr_c_max", c_max, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
